// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx                                                      |
// | Description : 8N1 UART receiver, mid-bit sampling, single-cycle strobes.   |
// |               Define UART_RX_PARITY_EN for 8E1 with o_parity_err.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_busy,
`ifdef UART_RX_PARITY_EN
   output logic       o_parity_err,
`endif
   output logic       o_frame_err
);

   localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   state_t             r_state, w_state_nxt;
   logic               r_sync1, r_sync2;
   logic               w_rx_s;
   logic [c_CNT_W-1:0] r_clk_cnt, w_clk_cnt_nxt;
   logic               w_clk_done;
   logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]         r_shift, w_shift_nxt;
   logic [7:0]         r_data, w_data_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_frame_err, w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
   logic               r_par_bit, w_par_bit_nxt;
   logic               r_parity_err, w_parity_err_nxt;
`endif

   // Idle-high line: synchronizer resets to 1 so reset never looks like a start bit
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_uart_rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s     = r_sync2;
   assign w_clk_done = (r_clk_cnt == c_FULL_M1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_clk_cnt    <= '0;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'h00;
         r_data       <= 8'h00;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_clk_cnt    <= w_clk_cnt_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_data       <= w_data_nxt;
         r_valid      <= w_valid_nxt;
         r_frame_err  <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= w_par_bit_nxt;
         r_parity_err <= w_parity_err_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_clk_cnt_nxt    = r_clk_cnt;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_shift_nxt      = r_shift;
      w_data_nxt       = r_data;
      w_valid_nxt      = 1'b0;
      w_frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bit_nxt    = r_par_bit;
      w_parity_err_nxt = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = 3'd0;
            if (!w_rx_s) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_clk_cnt == c_HALF_M1) begin
               w_clk_cnt_nxt = '0;
               w_bit_cnt_nxt = 3'd0;
               w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (w_clk_done) begin
               w_clk_cnt_nxt = '0;
               w_shift_nxt   = {w_rx_s, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_clk_done) begin
               w_clk_cnt_nxt = '0;
               w_par_bit_nxt = w_rx_s;
               w_state_nxt   = S_STOP;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
`endif
         S_STOP: begin
            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
            if (w_clk_done) begin
               w_clk_cnt_nxt = '0;
               if (!w_rx_s) begin
                  w_frame_err_nxt = 1'b1;
                  w_state_nxt     = S_WAIT_HIGH;
               end else begin
                  w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (r_par_bit != ^r_shift) begin
                     w_parity_err_nxt = 1'b1;
                  end else begin
                     w_valid_nxt = 1'b1;
                     w_data_nxt  = r_shift;
                  end
`else
                  w_valid_nxt = 1'b1;
                  w_data_nxt  = r_shift;
`endif
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (w_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = 3'd0;
         end
      endcase
   end

   assign o_data       = r_data;
   assign o_valid      = r_valid;
   assign o_frame_err  = r_frame_err;
   assign o_busy       = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire
